pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Reset and lock supervisor for the DAC clocking PLL. It drives the PLL `rst` input, watches the PLL `locked` output and releases downstream logic only after lock has been stable for a programmed interval. On loss of lock it re-runs the reset sequence. It gives up and raises a sticky fault after a bounded number of failed lock attempts. It runs on the 50 MHz reference clock, which is the only clock guaranteed to be running while the PLL is unlocked.

## Interface
- `RST_PULSE_CYCLES`, default 10: refclk cycles for which `pll_rst` is held high on each attempt; must be ≥1.
- `LOCK_TIMEOUT_CYCLES`, default 50000: refclk cycles (1 ms) allowed in WAIT_LOCK before the attempt is declared failed; must be ≥2.
- `LOCK_STABLE_CYCLES`, default 1024: consecutive refclk cycles of synchronized lock required before release; must be ≥1.
- `MAX_RETRIES`, default 3: additional attempts after the first before entering FAULT; legal range 0..15.

Ports:
- `refclk`, in, 1: reference clock, 50 MHz; the only clock in the block.
- `rst`, in, 1: reset, asynchronous and active-high.
- `pll_locked`, in, 1: PLL lock indicator, asynchronous to refclk; passed through a 2-flop synchronizer to form `locked_sync`.
- `relock_req`, in, 1: synchronous request to restart the sequence; clears `retry_count`.
- `pll_rst`, out, 1: drives the PLL reset input.
- `sys_rst`, out, 1: reset for downstream logic. Downstream 125 MHz domains resynchronize its deassertion locally.
- `ready`, out, 1: high only in RUN.
- `fault`, out, 1: high only in FAULT.
- `retry_count`, out, 4: number of failed attempts in the current episode.

## Operation
- States: RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAULT. A single shared cycle counter `cnt` is cleared on every state entry.
- **Reset values:** state RESET_PLL, `cnt`=0, `pll_rst`=1, `sys_rst`=1, `ready`=0, `fault`=0, `retry_count`=0, synchronizer flops 0.
- **RESET_PLL:** `pll_rst`=1, `sys_rst`=1. When `cnt`==RST_PULSE_CYCLES-1, go to WAIT_LOCK.
- **WAIT_LOCK:** `pll_rst`=0, `sys_rst`=1.
  - `locked_sync`=1 → STABILIZE.
  - Otherwise, when `cnt`==LOCK_TIMEOUT_CYCLES-1 the attempt has failed:
    - if `retry_count`==MAX_RETRIES → FAULT;
    - else increment `retry_count` and go to RESET_PLL.
- **STABILIZE:** `pll_rst`=0, `sys_rst`=1.
  - `locked_sync`=0 → WAIT_LOCK (timeout counter restarts from 0).
  - `cnt`==LOCK_STABLE_CYCLES-1 with `locked_sync`=1 → RUN.
- **RUN:** `pll_rst`=0, `sys_rst`=0, `ready`=1. `retry_count` is cleared on entry.
  - `locked_sync`=0 → RESET_PLL. This is a new episode, so `retry_count` stays 0.
- **FAULT:** `pll_rst`=1, `sys_rst`=1, `fault`=1. Held until `rst` is asserted or `relock_req` is seen.
- **relock_req:** in any state, including FAULT, it has top priority. It forces RESET_PLL, clears `cnt` and clears `retry_count`. Held high, it keeps the FSM in RESET_PLL with `pll_rst`=1.
- **Simultaneous events:**
  - `relock_req` together with lock loss in RUN behaves as `relock_req`.
  - Timeout and `locked_sync` rising on the same cycle in WAIT_LOCK: lock wins, go to STABILIZE.
- Total lock attempts before FAULT = MAX_RETRIES+1.

## Timing
- All outputs are registered, decoded from the next state, and change only on the rising edge of `refclk`. The exception is `rst`, which forces reset values immediately with no clock edge.
- Lock acquisition: `pll_locked` first sampled high at edge N → STABILIZE at edge N+2 → `ready`=1 and `sys_rst`=0 at edge N+2+LOCK_STABLE_CYCLES.
- Lock loss: `pll_locked` first sampled low at edge M while in RUN → `ready`=0, `sys_rst`=1 and `pll_rst`=1 at edge M+2.
- `pll_rst` high pulse lasts exactly RST_PULSE_CYCLES cycles.
- WAIT_LOCK without lock lasts exactly LOCK_TIMEOUT_CYCLES cycles.
- `relock_req` sampled at edge R → `pll_rst`=1, `ready`=0, `fault`=0 at edge R.
- Deasserting `rst` mid-operation restarts the sequence from RESET_PLL; no state is retained.

## Test plan
All scenarios use RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=100, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
- **Normal lock:** release `rst`; raise `pll_locked` 10 cycles after `pll_rst` falls → `pll_rst` pulse is exactly 4 cycles; `ready`=1 and `sys_rst`=0 exactly 10 edges after lock is first sampled; `retry_count`=0.
- **Never lock:** hold `pll_locked`=0 → three `pll_rst` pulses, each followed by 100 low cycles. After the third timeout: `fault`=1, `retry_count`=2, `pll_rst` stuck at 1, `ready`=0.
- **Lock glitch:** raise `pll_locked` for 5 cycles, drop it for 3, then hold high → no `ready` during the glitch; FSM returns to WAIT_LOCK; `ready` rises 10 edges after the final rise.
- **Lock loss in RUN:** drop `pll_locked` at edge M → at M+2 `ready`=0, `sys_rst`=1, `pll_rst`=1 for 4 cycles. Relock then completes normally with `retry_count`=0.
- **Recovery from FAULT:** in FAULT, pulse `relock_req` for 1 cycle, then supply lock → `fault` clears at that edge, `retry_count`=0, one 4-cycle `pll_rst` pulse, then `ready`=1.
- **Reset mid-operation:** assert `rst` between clock edges during STABILIZE → all outputs take their reset values immediately; on release, the sequence restarts with a 4-cycle `pll_rst` pulse.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencer and lock supervisor on the reference clock
//
// Purpose:
//   Pulses the PLL reset, waits for a synchronized lock indication, requires
//   lock to stay stable for a programmed interval, then releases downstream
//   reset. Loss of lock restarts the sequence. A bounded number of failed
//   attempts ends in a sticky fault that only rst or relock_req clears.
//
// Ports:
//   refclk      in   reference clock, the only clock in the block
//   rst         in   asynchronous active-high reset
//   pll_locked  in   PLL lock indicator, asynchronous to refclk
//   relock_req  in   synchronous request to restart the sequence
//   pll_rst     out  PLL reset input
//   sys_rst     out  downstream reset (deassertion resynchronized by consumers)
//   ready       out  high only while running with stable lock
//   fault       out  high only in the sticky fault state
//   retry_count out  failed attempts in the current episode

module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 10,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count
);

  // One counter is shared by all timed states, so it is sized for the longest.
  localparam int CNT_MAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                             RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ?
                             CNT_MAX_A : LOCK_STABLE_CYCLES;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0]       retry_nxt;
  logic             sync_q1;
  logic             locked_sync;

  logic             pll_rst_nxt;
  logic             sys_rst_nxt;
  logic             ready_nxt;
  logic             fault_nxt;

  // Two-flop synchronizer for the asynchronous lock indicator.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q1     <= 1'b0;
      locked_sync <= 1'b0;
    end else begin
      sync_q1     <= pll_locked;
      locked_sync <= sync_q1;
    end
  end

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_count;

    if (relock_req) begin
      // Highest priority in every state, including FAULT and RESET_PLL.
      state_nxt = RESET_PLL;
      retry_nxt = 4'd0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          // Lock wins over a timeout on the same cycle.
          if (locked_sync) begin
            state_nxt = STABILIZE;
          end else if (cnt == TIMEOUT_LAST) begin
            if (retry_count == RETRY_LIMIT) begin
              state_nxt = FAULT;
            end else begin
              state_nxt = RESET_PLL;
              retry_nxt = retry_count + 4'd1;
            end
          end
        end
        STABILIZE: begin
          if (!locked_sync) begin
            state_nxt = WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            state_nxt = RUN;
            retry_nxt = 4'd0;
          end
        end
        RUN: begin
          // A lock loss here starts a new episode; retry_count is already 0.
          if (!locked_sync) state_nxt = RESET_PLL;
        end
        FAULT: begin
          state_nxt = FAULT;
        end
        default: begin
          state_nxt = RESET_PLL;
        end
      endcase
    end

    // Counter restarts on any state entry and on relock_req (which may
    // re-enter RESET_PLL from RESET_PLL). It only runs in timed states.
    if (relock_req || (state_nxt != state)) begin
      cnt_nxt = '0;
    end else if ((state == RESET_PLL) || (state == WAIT_LOCK) ||
                 (state == STABILIZE)) begin
      cnt_nxt = cnt + 1'b1;
    end else begin
      cnt_nxt = cnt;
    end

    // Outputs are decoded from the next state so they register together
    // with the state transition.
    pll_rst_nxt = (state_nxt == RESET_PLL) || (state_nxt == FAULT);
    sys_rst_nxt = (state_nxt != RUN);
    ready_nxt   = (state_nxt == RUN);
    fault_nxt   = (state_nxt == FAULT);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state       <= RESET_PLL;
      cnt         <= '0;
      retry_count <= 4'd0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      retry_count <= retry_nxt;
      pll_rst     <= pll_rst_nxt;
      sys_rst     <= sys_rst_nxt;
      ready       <= ready_nxt;
      fault       <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - self-checking bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

  localparam int P = 4;
  localparam int T = 100;
  localparam int S = 8;
  localparam int M = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;

  always #10 refclk = ~refclk;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES   (P),
    .LOCK_TIMEOUT_CYCLES(T),
    .LOCK_STABLE_CYCLES (S),
    .MAX_RETRIES        (M)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fault      (fault),
    .retry_count(retry_count)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: phase plus a count-down of cycles remaining in it.
  localparam int PH_PULSE = 0, PH_WAIT = 1, PH_STAB = 2, PH_RUN = 3, PH_FAULT = 4;
  int   ph;
  int   left;
  int   retries;
  logic sy1, sy2;

  task automatic model_reset();
    ph = PH_PULSE; left = P; retries = 0; sy1 = 1'b0; sy2 = 1'b0;
  endtask

  task automatic model_edge();
    logic ls;
    ls  = sy2;
    sy2 = sy1;
    sy1 = pll_locked;
    if (relock_req) begin
      ph = PH_PULSE; left = P; retries = 0;
    end else begin
      case (ph)
        PH_PULSE: begin
          left--;
          if (left == 0) begin ph = PH_WAIT; left = T; end
        end
        PH_WAIT: begin
          if (ls) begin
            ph = PH_STAB; left = S;
          end else begin
            left--;
            if (left == 0) begin
              if (retries == M) ph = PH_FAULT;
              else begin retries++; ph = PH_PULSE; left = P; end
            end
          end
        end
        PH_STAB: begin
          if (!ls) begin
            ph = PH_WAIT; left = T;
          end else begin
            left--;
            if (left == 0) begin ph = PH_RUN; retries = 0; end
          end
        end
        PH_RUN: if (!ls) begin ph = PH_PULSE; left = P; end
        default: ;
      endcase
    end
  endtask

  task automatic check(input string name);
    logic [7:0] exp_v, got_v;
    exp_v = {(ph == PH_PULSE) || (ph == PH_FAULT), ph != PH_RUN, ph == PH_RUN,
             ph == PH_FAULT, 4'(retries)};
    got_v = {pll_rst, sys_rst, ready, fault, retry_count};
    tests++;
    if (got_v !== exp_v) begin
      fails++;
      $display("FAIL %s t=%0t: got pll_rst/sys_rst/ready/fault/retry=%b_%b_%b_%b_%0d required %b_%b_%b_%b_%0d",
               name, $time, got_v[7], got_v[6], got_v[5], got_v[4], got_v[3:0],
               exp_v[7], exp_v[6], exp_v[5], exp_v[4], exp_v[3:0]);
    end
  endtask

  task automatic expect_int(input string name, input int got, input int exp_v);
    tests++;
    if (got != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, exp_v);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    if (rst) model_reset();
    else model_edge();
    #1 check("cycle");
  endtask

  task automatic async_reset();
    #4 rst = 1'b1;
    #1 model_reset();
    check("async_rst");
    expect_int("async_rst_lit", {pll_rst, sys_rst, ready, fault, retry_count}, 8'b1100_0000);
  endtask

  task automatic relock_pulse();
    relock_req = 1'b1;
    step();
    expect_int("relock_pll_rst", {pll_rst, ready, fault}, 3'b100);
    relock_req = 1'b0;
  endtask

  task automatic count_to_ready(output int n);
    n = 0;
    while (!ready && n < 1000) begin step(); n++; end
  endtask

  int n;
  int hold;
  logic seen_ready;

  initial begin
    model_reset();
    #15 check("reset");
    expect_int("reset_lit", {pll_rst, sys_rst, ready, fault, retry_count}, 8'b1100_0000);
    #5 rst = 1'b0;  // between edges

    // Normal lock
    n = 0;
    do begin step(); n++; end while (pll_rst && n < 100);
    expect_int("first_pulse_len", n, 4);
    repeat (10) step();
    pll_locked = 1'b1;
    step();
    count_to_ready(n);
    expect_int("lock_to_ready", n, 10);
    expect_int("lock_sysrst_retry", {sys_rst, retry_count}, 5'b0_0000);

    // Lock loss in RUN
    repeat (5) step();
    pll_locked = 1'b0;
    step();
    n = 0;
    while (ready && n < 100) begin step(); n++; end
    expect_int("loss_latency", n, 2);
    expect_int("loss_outputs", {pll_rst, sys_rst}, 2'b11);
    n = 0;
    while (pll_rst && n < 100) begin n++; step(); end
    expect_int("loss_pulse_len", n, 4);
    pll_locked = 1'b1;
    count_to_ready(n);
    expect_int("relock_retry", {ready, retry_count}, 5'b1_0000);

    // Lock glitch
    pll_locked = 1'b0;
    relock_pulse();
    repeat (4) step();
    seen_ready = 1'b0;
    pll_locked = 1'b1;
    repeat (5) begin step(); seen_ready |= ready; end
    pll_locked = 1'b0;
    repeat (3) begin step(); seen_ready |= ready; end
    pll_locked = 1'b1;
    step();
    seen_ready |= ready;
    count_to_ready(n);
    expect_int("glitch_no_ready", int'(seen_ready), 0);
    expect_int("glitch_to_ready", n, 10);

    // Never lock
    pll_locked = 1'b0;
    relock_pulse();
    n = 0;
    while (!fault && n < 1000) begin step(); n++; end
    expect_int("never_lock_cycles", n, 3 * (P + T));
    expect_int("fault_outputs", {pll_rst, ready, fault, retry_count}, 7'b101_0010);
    repeat (20) step();

    // Recovery from FAULT
    relock_pulse();
    expect_int("recover_clear", {fault, retry_count}, 5'b0_0000);
    pll_locked = 1'b1;
    n = 0;
    while (pll_rst && n < 100) begin n++; step(); end
    expect_int("recover_pulse_len", n, 4);
    count_to_ready(n);
    expect_int("recover_ready", int'(ready), 1);

    // Reset mid-operation during STABILIZE
    pll_locked = 1'b0;
    relock_pulse();
    repeat (4) step();
    pll_locked = 1'b1;
    repeat (5) step();
    async_reset();
    repeat (3) step();
    #2 rst = 1'b0;
    pll_locked = 1'b0;
    n = 0;
    do begin step(); n++; end while (pll_rst && n < 100);
    expect_int("post_rst_pulse_len", n, 4);

    // Randomized stimulus against the model
    hold = 0;
    for (int i = 0; i < 20000; i++) begin
      if (hold == 0) begin
        pll_locked = $urandom_range(0, 2) != 0;
        hold = $urandom_range(1, 150);
      end
      hold--;
      relock_req = ($urandom_range(0, 299) == 0);
      step();
      if ($urandom_range(0, 1999) == 0) begin
        async_reset();
        step();
        #2 rst = 1'b0;
      end
    end
    relock_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
